// File: rtl/xdma_h2c_desc_sched_pkg.sv
// Shared constants, FSM state type and small helpers for the H2C descriptor scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package xdma_h2c_desc_sched_pkg;

  // Descriptor control word: EOP set, stop and completed bits clear.
  localparam logic [15:0] BYP_CTL_EOP = 16'h0010;

  localparam int DESC_LEN_W  = 28;
  localparam int DESC_ADDR_W = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sched_state_t;

  // Round-robin successor of a granted requester index.
  function automatic int rr_advance(input int id, input int n);
    return (id + 1) % n;
  endfunction

endpackage

// File: rtl/xdma_h2c_desc_sched_if.sv
// Bundles requester, descriptor-bypass and H2C stream signals of the scheduler.
// Latency: none (wiring only).
// Backpressure: req_ready, byp_ready, s_tready and m_tready carry the handshakes.
interface xdma_h2c_desc_sched_if
  import xdma_h2c_desc_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 256
);

  // Requester side
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ*DESC_ADDR_W-1:0] req_addr;
  logic [N_REQ*DESC_LEN_W-1:0]  req_len;

  // XDMA descriptor bypass side
  logic                         byp_load;
  logic                         byp_ready;
  logic [DESC_ADDR_W-1:0]       byp_src_addr;
  logic [DESC_ADDR_W-1:0]       byp_dst_addr;
  logic [DESC_LEN_W-1:0]        byp_len;
  logic [15:0]                  byp_ctl;

  // XDMA H2C stream in
  logic                         s_tvalid;
  logic                         s_tlast;
  logic [DATA_W-1:0]            s_tdata;
  logic [DATA_W/8-1:0]          s_tkeep;
  logic                         s_tready;

  // Per-requester stream out
  logic [N_REQ-1:0]             m_tvalid;
  logic [N_REQ-1:0]             m_tready;
  logic [DATA_W-1:0]            m_tdata;
  logic [DATA_W/8-1:0]          m_tkeep;
  logic                         m_tlast;

  // Scheduler side
  modport master (
    input  req_valid, req_addr, req_len,
    input  byp_ready,
    input  s_tvalid, s_tlast, s_tdata, s_tkeep,
    input  m_tready,
    output req_ready,
    output byp_load, byp_src_addr, byp_dst_addr, byp_len, byp_ctl,
    output s_tready,
    output m_tvalid, m_tdata, m_tkeep, m_tlast
  );

  // User logic / XDMA side
  modport slave (
    output req_valid, req_addr, req_len,
    output byp_ready,
    output s_tvalid, s_tlast, s_tdata, s_tkeep,
    output m_tready,
    input  req_ready,
    input  byp_load, byp_src_addr, byp_dst_addr, byp_len, byp_ctl,
    input  s_tready,
    input  m_tvalid, m_tdata, m_tkeep, m_tlast
  );

endinterface

// File: rtl/xdma_route_fifo.sv
// Ordered queue of requester ids for descriptors whose stream packet has not yet ended.
// Latency: head valid the cycle after a push into an empty queue; pop takes effect at the edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module xdma_route_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [W-1:0]              push_id,
  input  logic                      pop,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Id storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/xdma_h2c_desc_sched.sv
// Round-robin sharing of the XDMA H2C descriptor bypass among N_REQ requesters, routing returned packets back.
// Latency: grant to byp_load 1 cycle (1 descriptor per 2 cycles peak); stream s_* to m_* combinational.
// Backpressure: no grant while a descriptor awaits byp_ready or ROUTE_DEPTH are outstanding; s_tready = m_tready of routed requester.
module xdma_h2c_desc_sched
  import xdma_h2c_desc_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ROUTE_DEPTH = 8,
  parameter int DATA_W      = 256
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  xdma_h2c_desc_sched_if.master         bus,
  output logic [$clog2(ROUTE_DEPTH):0]  outstanding,
  output logic                          err_zero_len
);

  // N_REQ >= 2 keeps ID_W non-zero; ROUTE_DEPTH must be a power of two.
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ROUTE_DEPTH) + 1;

  sched_state_t           state;
  logic [ID_W-1:0]        rr;
  logic [ID_W-1:0]        cur_id;
  logic [ID_W-1:0]        grant_id;
  logic                   grant_any;
  logic                   can_grant;
  logic [DESC_ADDR_W-1:0] grant_addr;
  logic [DESC_LEN_W-1:0]  grant_len;
  logic                   route_push;
  logic                   route_pop;
  logic [ID_W-1:0]        route_head;
  logic                   route_full;
  logic                   route_empty;
  logic [CNT_W-1:0]       fifo_cnt;
  logic [DATA_W-1:0]      data_bcast;

  // Search downward so the lowest offset from rr wins: first valid requester at or after rr.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr) + k) % N_REQ]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'((int'(rr) + k) % N_REQ);
      end
    end
  end

  assign grant_addr = bus.req_addr[int'(grant_id)*DESC_ADDR_W +: DESC_ADDR_W];
  assign grant_len  = bus.req_len[int'(grant_id)*DESC_LEN_W +: DESC_LEN_W];

  // The descriptor sitting in ISSUE holds one reserved route slot until it is loaded.
  assign outstanding = fifo_cnt + CNT_W'(state == ST_ISSUE);

  // Reset gates the grant so req_ready is quiet while RST_N is held low.
  assign can_grant = RST_N && (state == ST_IDLE) && grant_any && !route_full &&
                     (outstanding < CNT_W'(ROUTE_DEPTH));

  // Combinational accept strobe to the granted requester only.
  always_comb begin
    bus.req_ready = '0;
    if (can_grant) bus.req_ready[grant_id] = 1'b1;
  end

  // Issue FSM: latch the granted request, hold byp_load until XDMA takes it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state            <= ST_IDLE;
      rr               <= '0;
      cur_id           <= '0;
      bus.byp_load     <= 1'b0;
      bus.byp_src_addr <= '0;
      bus.byp_len      <= '0;
      bus.byp_ctl      <= '0;
      err_zero_len     <= 1'b0;
    end else begin
      err_zero_len <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (can_grant) begin
            rr <= ID_W'(rr_advance(int'(grant_id), N_REQ));
            if (grant_len == '0) begin
              // Zero-length descriptors are consumed and flagged, never sent to XDMA.
              err_zero_len <= 1'b1;
            end else begin
              state            <= ST_ISSUE;
              cur_id           <= grant_id;
              bus.byp_load     <= 1'b1;
              bus.byp_src_addr <= grant_addr;
              bus.byp_len      <= grant_len;
              bus.byp_ctl      <= BYP_CTL_EOP;
            end
          end
        end
        ST_ISSUE: begin
          if (bus.byp_ready) begin
            state        <= ST_IDLE;
            bus.byp_load <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stream mode: XDMA ignores the destination address.
  assign bus.byp_dst_addr = '0;

  // The loaded descriptor moves from reserved to queued in the same cycle.
  assign route_push = (state == ST_ISSUE) && bus.byp_ready;

  xdma_route_fifo #(
    .W     (ID_W),
    .DEPTH (ROUTE_DEPTH)
  ) u_route_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push    (route_push),
    .push_id (cur_id),
    .pop     (route_pop),
    .head    (route_head),
    .full    (route_full),
    .empty   (route_empty),
    .count   (fifo_cnt)
  );

  // Steer valid/ready between the XDMA stream and the requester at the head of the route queue.
  always_comb begin
    bus.m_tvalid = '0;
    bus.s_tready = 1'b0;
    if (!route_empty) begin
      bus.m_tvalid[route_head] = bus.s_tvalid;
      bus.s_tready             = bus.m_tready[route_head];
    end
  end

  // A packet ends on its accepted tlast beat, retiring its route entry.
  assign route_pop = bus.s_tvalid && bus.s_tready && bus.s_tlast;

  assign data_bcast  = bus.s_tdata;
  assign bus.m_tdata = data_bcast;
  assign bus.m_tkeep = bus.s_tkeep;
  assign bus.m_tlast = bus.s_tlast;

endmodule

// File: doc/xdma_h2c_desc_sched.md
# xdma_h2c_desc_sched

Shares the single XDMA H2C descriptor-bypass channel among `N_REQ` user-logic requesters, sitting between user logic and the `xdma_0` H2C bypass and stream ports. It arbitrates descriptor requests round-robin and drives the bypass load handshake. It also records the grant order so each returning H2C stream packet is routed back to the requester that issued it.

## Interface
- `N_REQ`, default 4: number of requesters; must be at least 2.
- `ROUTE_DEPTH`, default 8: maximum number of outstanding descriptors, counted from issue to the returned packet's `tlast`; power of 2.
- `DATA_W`, default 256: H2C stream width.
- `CLK` in 1: clock, the XDMA `axi_aclk` domain.
- `RST_N` in 1: reset, synchronous and active-low.
- `req_valid` in N_REQ: one descriptor request per requester.
- `req_ready` out N_REQ: request accepted this cycle; at most one bit set.
- `req_addr` in N_REQ*64: host source address per requester; slice i = bits [64i+63:64i].
- `req_len` in N_REQ*28: byte length per requester.
- `byp_load` out 1: maps to `h2c_dsc_byp_load_0`.
- `byp_ready` in 1: maps to `h2c_dsc_byp_ready_0`.
- `byp_src_addr` out 64: descriptor source address.
- `byp_dst_addr` out 64: descriptor destination address.
- `byp_len` out 28: descriptor length.
- `byp_ctl` out 16: descriptor control field.
- `s_tvalid`, `s_tlast` in 1: XDMA H2C stream valid and last.
- `s_tdata` in DATA_W: XDMA H2C stream data.
- `s_tkeep` in DATA_W/8: XDMA H2C stream byte enables.
- `s_tready` out 1: ready back to the XDMA H2C stream.
- `m_tvalid` out N_REQ: per-requester stream valid.
- `m_tready` in N_REQ: per-requester stream ready.
- `m_tdata`, `m_tkeep`, `m_tlast` out: broadcast copies of the `s_*` signals.
- `outstanding` out log2(ROUTE_DEPTH)+1: number of occupied plus reserved route slots.
- `err_zero_len` out 1: one-cycle pulse when a zero-length request is dropped.

## Operation
- Issue FSM has two states, IDLE and ISSUE.
- IDLE transition condition: any `req_valid` is set and `outstanding < ROUTE_DEPTH`.
  - Grant g is the first valid requester at or after round-robin pointer `rr`, searching upward modulo N_REQ.
  - `req_ready[g]` is asserted combinationally in that same cycle.
  - The request is latched into the `byp_*` registers and g is latched into `cur_id`.
  - `rr` becomes (g+1) mod N_REQ.
  - The reserved count is incremented and the FSM moves to ISSUE.
- Zero-length request in IDLE: it is granted and `rr` advances. `err_zero_len` pulses, nothing is reserved, and the FSM stays in IDLE.
- ISSUE state:
  - `byp_load` is held at 1 until the first cycle in which `byp_ready` is 1.
  - In that cycle `cur_id` is pushed into the route FIFO and the reserve is released, leaving `outstanding` net unchanged.
  - The FSM then returns to IDLE.
- Fixed descriptor fields: `byp_dst_addr` = 0 (stream mode); `byp_ctl` = 16'h0010 (EOP set; stop and completed bits clear).
- Routing when the route FIFO is empty: `s_tready` = 0 and all `m_tvalid` = 0.
- Routing when the route FIFO is non-empty, with head id h:
  - `m_tvalid[h]` = `s_tvalid`; all other bits are 0.
  - `s_tready` = `m_tready[h]`.
- A handshake beat with `s_tlast` = 1 pops the head and decrements `outstanding`.
- Same-cycle push (ISSUE completion) and pop (`tlast`) are both performed. Push and pop each act on their own counter term.
- Packets are assumed to return in issue order; XDMA H2C single-channel guarantees this.

## Timing
- Values on reset: FSM = IDLE, `rr` = 0, route FIFO empty, `outstanding` = 0.
- All outputs are 0 on reset: `byp_load`, `req_ready`, `m_tvalid`, `s_tready`, `err_zero_len`, `byp_*`.
- Request acceptance to first `byp_load`: 1 cycle.
- Peak descriptor rate: 1 per 2 cycles when `byp_ready` is constantly 1.
- `byp_*` values are stable while `byp_load` = 1.
- Stream path from `s_*` to `m_*` is combinational; there is no added latency and no beat is stored.
- Backpressure at `outstanding == ROUTE_DEPTH`: no grant is issued and no `req_ready` bit is set until a `tlast` pop occurs. A grant is possible in the cycle after the pop.
- Reset mid-operation drops all state. `RST_N` must be asserted together with the XDMA `axi_aresetn`; in-flight descriptors are not recovered.

## Structure
- Shared package holds:
  - the `BYP_CTL_EOP` = 16'h0010 constant;
  - the `DESC_LEN_W` = 28 and `DESC_ADDR_W` = 64 constants;
  - the FSM state enum.
- Natural sub-module: `xdma_route_fifo`.
  - Width log2(N_REQ), depth ROUTE_DEPTH.
  - Push, pop, and head ports; full and empty flags.
  - Simultaneous push/pop is legal, including on an empty FIFO with push only, or a full FIFO with pop only.

## Test plan
- Round-robin order:
  - Stimulus: requesters 0,1,2,3 all valid with len=64; `byp_ready`=1.
  - Required: grants in order 0,1,2,3,0; `byp_load` every other cycle; `byp_ctl`=16'h0010.
- Load stall:
  - Stimulus: one request with addr=0x1000_0000, len=4096; `byp_ready` low for 5 cycles.
  - Required: `byp_load` held for 6 cycles; `byp_src_addr` stable; exactly 1 route push.
- Routing:
  - Stimulus: issue ids 2 then 0; return a 3-beat packet then a 1-beat packet.
  - Required: beats appear on `m_tvalid[2]` only, then on `m_tvalid[0]` only; `outstanding` goes 2→1→0.
- Full:
  - Stimulus: 8 descriptors issued with no stream return.
  - Required: `outstanding`=8 and the ninth request is not granted. After one `tlast` pop, the ninth request is granted on the next cycle.
- Edge cases:
  - Stimulus: a len=0 request; separately, push and pop in the same cycle.
  - Required: for len=0, `err_zero_len` pulses once and there is no `byp_load`. For same-cycle push and pop, `outstanding` is unchanged.
- Reset:
  - Stimulus: `RST_N` low during ISSUE with 3 outstanding.
  - Required: next cycle all outputs are 0, `outstanding`=0, and the FSM is in IDLE.
